// File: rtl/spi_flash_controller_pkg.sv
// rtl/spi_flash_controller_pkg.sv - shared constants and types for the SPI flash bridge
// Contents: flash opcodes, fixed upper address byte, frame geometry, bus-side state enum.
package spi_flash_controller_pkg;

  localparam logic [7:0] READ_CMD  = 8'h03;
  localparam logic [7:0] WRITE_CMD = 8'h02;
  localparam logic [7:0] WREN      = 8'h06;
  localparam logic [7:0] ADDR_HI   = 8'h00;

  // opcode + 24-bit address + one data byte
  localparam int FRAME_LEN  = 40;
  // first bit index of the data byte within the frame
  localparam int DATA_START = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - generic N-bit SPI mode-0 frame shifter with MISO capture
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   i_start          : load i_frame and begin a frame (ignored while busy)
//   i_frame          : frame to send, MSB first
//   i_miso           : serial data from the device, sampled on SCK rise
//   o_sck/o_mosi     : SCK (clk/2) and serial data to the device
//   o_cs_n           : active-low chip select
//   o_last           : high during the cycle whose closing edge ends the frame
//   o_rx             : last CAP_W bits sampled from bit CAP_START onward
module spi_shift_engine #(
  parameter int N         = 40,
  parameter int CAP_START = 32,
  parameter int CAP_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [N-1:0]     i_frame,
  input  logic             i_miso,
  output logic             o_sck,
  output logic             o_mosi,
  output logic             o_cs_n,
  output logic             o_last,
  output logic [CAP_W-1:0] o_rx
);

  localparam int CW = $clog2(N + 1);

  logic             r_busy;
  logic             r_sck;
  logic             r_mosi;
  logic             r_cs_n;
  logic [N-1:0]     r_shift;
  logic [CW-1:0]    r_bits;   // falling edges completed = index of the bit on MOSI
  logic [CAP_W-1:0] r_rx;

  // After the final falling edge, one more cycle with SCK low before CS rises.
  assign o_last = r_busy && (r_bits == CW'(N));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_shift <= '0;
      r_bits  <= '0;
      r_rx    <= '0;
    end else if (!r_busy) begin
      if (i_start) begin
        r_busy  <= 1'b1;
        r_cs_n  <= 1'b0;
        r_sck   <= 1'b0;
        r_shift <= i_frame;
        r_mosi  <= i_frame[N-1];
        r_bits  <= '0;
        r_rx    <= '0;
      end
    end else if (o_last) begin
      r_busy <= 1'b0;
      r_cs_n <= 1'b1;
      r_mosi <= 1'b0;
    end else if (!r_sck) begin
      r_sck <= 1'b1;
      if (r_bits >= CW'(CAP_START)) begin
        r_rx <= {r_rx[CAP_W-2:0], i_miso};
      end
    end else begin
      // Zero fill means MOSI returns low after the last bit.
      r_sck   <= 1'b0;
      r_shift <= {r_shift[N-2:0], 1'b0};
      r_mosi  <= r_shift[N-2];
      r_bits  <= r_bits + CW'(1);
    end
  end

  assign o_sck  = r_sck;
  assign o_mosi = r_mosi;
  assign o_cs_n = r_cs_n;
  assign o_rx   = r_rx;

endmodule

// File: rtl/spi_flash_controller.sv
// rtl/spi_flash_controller.sv - parallel bus to SPI NOR flash single-byte read/program bridge
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   spi_ce            : transaction request from the bus decoder
//   i_ADDRESS_BUS     : 16-bit byte address
//   i_DataBus         : write data
//   i_RW              : 1 = read (0x03), 0 = page program (0x02)
//   i_SPI_MISO        : flash serial output
//   o_SPI_CLK/MOSI/CS : flash pins (mode 0, CS active-low)
//   o_spi_data        : last byte read
//   o_MemoryReady     : transaction complete, held while spi_ce stays high
module spi_flash_controller
  import spi_flash_controller_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_ce,
  input  logic [15:0] i_ADDRESS_BUS,
  input  logic [7:0]  i_DataBus,
  input  logic        i_RW,
  input  logic        i_SPI_MISO,
  output logic        o_SPI_CLK,
  output logic        o_SPI_MOSI,
  output logic        o_SPI_CS,
  output logic [7:0]  o_spi_data,
  output logic        o_MemoryReady
);

  state_t      r_state;
  logic        r_rw;
  logic        r_ready;
  logic [7:0]  r_data;

  logic                 w_start;
  logic                 w_last;
  logic [FRAME_LEN-1:0] w_frame;
  logic [7:0]           w_rx;

  assign w_start = (r_state == ST_IDLE) && spi_ce;
  // The engine latches the frame on the start edge, so later bus changes are ignored.
  assign w_frame = {(i_RW ? READ_CMD : WRITE_CMD), ADDR_HI, i_ADDRESS_BUS,
                    (i_RW ? 8'h00 : i_DataBus)};

  spi_shift_engine #(
    .N         (FRAME_LEN),
    .CAP_START (DATA_START),
    .CAP_W     (8)
  ) u_engine (
    .clk     (clk),
    .rst     (reset),
    .i_start (w_start),
    .i_frame (w_frame),
    .i_miso  (i_SPI_MISO),
    .o_sck   (o_SPI_CLK),
    .o_mosi  (o_SPI_MOSI),
    .o_cs_n  (o_SPI_CS),
    .o_last  (w_last),
    .o_rx    (w_rx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_rw    <= 1'b0;
      r_ready <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b0;
          if (spi_ce) begin
            r_rw    <= i_RW;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // spi_ce is not watched here: a started frame always completes.
          if (w_last) begin
            r_state <= ST_DONE;
            r_ready <= 1'b1;
            if (r_rw) begin
              r_data <= w_rx;
            end
          end
        end
        ST_DONE: begin
          if (!spi_ce) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_spi_data    = r_data;
  assign o_MemoryReady = r_ready;

endmodule

// File: tb/tb_spi_flash_controller.sv
// tb/tb_spi_flash_controller.sv - self-checking bench for spi_flash_controller
module tb_spi_flash_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_ce = 1'b0;
  logic [15:0] i_ADDRESS_BUS = 16'h0;
  logic [7:0]  i_DataBus = 8'h0;
  logic        i_RW = 1'b0;
  logic        i_SPI_MISO = 1'b0;
  logic        o_SPI_CLK;
  logic        o_SPI_MOSI;
  logic        o_SPI_CS;
  logic [7:0]  o_spi_data;
  logic        o_MemoryReady;

  int n_checks = 0;
  int n_fail   = 0;

  // flash-side observation
  int          sck_cnt   = 0;
  int          sck_total = 0;
  int          cs_falls  = 0;
  logic [39:0] mosi_frame = '0;
  logic [7:0]  miso_byte = 8'h00;
  time         cs_rise_t = 0;
  time         cs_gap = 0;

  // behavioural state
  logic [7:0]  exp_data = 8'h00;

  always #5 clk = ~clk;

  spi_flash_controller dut (
    .clk           (clk),
    .reset         (reset),
    .spi_ce        (spi_ce),
    .i_ADDRESS_BUS (i_ADDRESS_BUS),
    .i_DataBus     (i_DataBus),
    .i_RW          (i_RW),
    .i_SPI_MISO    (i_SPI_MISO),
    .o_SPI_CLK     (o_SPI_CLK),
    .o_SPI_MOSI    (o_SPI_MOSI),
    .o_SPI_CS      (o_SPI_CS),
    .o_spi_data    (o_spi_data),
    .o_MemoryReady (o_MemoryReady)
  );

  always @(negedge o_SPI_CS) begin
    sck_cnt    = 0;
    mosi_frame = '0;
    cs_falls++;
    cs_gap = $time - cs_rise_t;
  end

  always @(posedge o_SPI_CS) cs_rise_t = $time;

  // Flash model: MOSI read on SCK rise; after rise c, present data bit for rise index c.
  always @(posedge o_SPI_CLK) begin
    sck_total++;
    if (!o_SPI_CS) begin
      mosi_frame = {mosi_frame[38:0], o_SPI_MOSI};
      sck_cnt++;
      if (sck_cnt >= 32 && sck_cnt < 40) i_SPI_MISO = miso_byte[39 - sck_cnt];
      else                               i_SPI_MISO = 1'($urandom);
    end
  end

  function automatic logic [39:0] model_frame(input logic rw, input logic [15:0] a,
                                              input logic [7:0] d);
    return {(rw ? 8'h03 : 8'h02), 8'h00, a, (rw ? 8'h00 : d)};
  endfunction

  // Stimulus only: runs one transaction and reports latency and ready length.
  task automatic do_txn(input logic rw, input logic [15:0] a, input logic [7:0] d,
                        input logic [7:0] mb, input int drop_at, input int hold,
                        input bit no_wait, output int lat, output int rdy_len);
    if (!no_wait) @(negedge clk);
    i_RW = rw; i_ADDRESS_BUS = a; i_DataBus = d; miso_byte = mb; spi_ce = 1'b1;
    @(posedge clk);  // E0
    #1;
    i_RW = 1'($urandom); i_ADDRESS_BUS = 16'($urandom); i_DataBus = 8'($urandom);
    lat = -1; rdy_len = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (n == drop_at) spi_ce = 1'b0;
      if (o_MemoryReady) begin lat = n; break; end
    end
    if (lat < 0) begin spi_ce = 1'b0; return; end
    rdy_len = 1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (o_MemoryReady) rdy_len++;
    end
    spi_ce = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (!o_MemoryReady) break;
      rdy_len++;
    end
  endtask

  task automatic test_reset;
    int s0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({o_SPI_CS, o_SPI_CLK, o_SPI_MOSI, o_spi_data, o_MemoryReady} !== {3'b100, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: cs=%b sck=%b mosi=%b data=%h rdy=%b, required cs=1 sck=0 mosi=0 data=00 rdy=0",
               o_SPI_CS, o_SPI_CLK, o_SPI_MOSI, o_spi_data, o_MemoryReady);
    end
    @(negedge clk); reset = 1'b0;
    s0 = sck_total;
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (sck_total !== s0 || o_SPI_CS !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_quiet: sck pulses %0d cs=%b, required 0 pulses cs=1", sck_total - s0, o_SPI_CS);
    end
  endtask

  task automatic test_read_directed;
    int lat, rl;
    do_txn(1'b1, 16'h3AAA, 8'h55, 8'hFA, 0, 0, 1'b0, lat, rl);
    exp_data = 8'hFA;
    n_checks++;
    if (lat !== 81) begin n_fail++; $display("FAIL read_latency: %0d, required 81", lat); end
    n_checks++;
    if (sck_cnt !== 40) begin n_fail++; $display("FAIL read_sck_count: %0d, required 40", sck_cnt); end
    n_checks++;
    if (mosi_frame !== 40'h0300_3AAA_00) begin
      n_fail++; $display("FAIL read_mosi: %h, required 03003aaa00", mosi_frame);
    end
    n_checks++;
    if (o_spi_data !== exp_data) begin n_fail++; $display("FAIL read_data: %h, required %h", o_spi_data, exp_data); end
  endtask

  task automatic test_read_early_drop;
    int lat, rl;
    logic [7:0] mb;
    mb = 8'($urandom);
    do_txn(1'b1, 16'h3AAA, 8'h00, mb, 50, 0, 1'b0, lat, rl);
    exp_data = mb;
    n_checks++;
    if (lat !== 81 || sck_cnt !== 40) begin
      n_fail++; $display("FAIL drop_complete: latency %0d sck %0d, required 81 and 40", lat, sck_cnt);
    end
    n_checks++;
    if (rl !== 1) begin n_fail++; $display("FAIL drop_ready_pulse: %0d cycles, required 1", rl); end
    n_checks++;
    if (o_spi_data !== exp_data) begin n_fail++; $display("FAIL drop_data: %h, required %h", o_spi_data, exp_data); end
  endtask

  task automatic test_write_hold;
    int lat, rl, f0;
    f0 = cs_falls;
    do_txn(1'b0, 16'h3000, 8'hAA, 8'h3C, 0, 6, 1'b0, lat, rl);
    n_checks++;
    if (mosi_frame !== 40'h0200_3000_AA || sck_cnt !== 40) begin
      n_fail++; $display("FAIL write_mosi: %h sck %0d, required 02003000aa and 40", mosi_frame, sck_cnt);
    end
    n_checks++;
    if (lat !== 81) begin n_fail++; $display("FAIL write_latency: %0d, required 81", lat); end
    n_checks++;
    if (o_spi_data !== exp_data) begin n_fail++; $display("FAIL write_data_kept: %h, required %h", o_spi_data, exp_data); end
    n_checks++;
    if (rl !== 7 || cs_falls - f0 !== 1) begin
      n_fail++; $display("FAIL write_no_retrigger: ready %0d cycles, cs falls %0d, required 7 and 1", rl, cs_falls - f0);
    end
  endtask

  task automatic test_reset_mid;
    int lat, rl;
    @(negedge clk);
    i_RW = 1'b1; i_ADDRESS_BUS = 16'h1234; miso_byte = 8'hC3; spi_ce = 1'b1;
    @(posedge clk);  // E0
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    exp_data = 8'h00;
    n_checks++;
    if (o_SPI_CS !== 1'b1 || o_SPI_CLK !== 1'b0 || o_MemoryReady !== 1'b0 || o_spi_data !== exp_data) begin
      n_fail++; $display("FAIL reset_mid: cs=%b sck=%b rdy=%b data=%h, required 1 0 0 00",
                         o_SPI_CS, o_SPI_CLK, o_MemoryReady, o_spi_data);
    end
    spi_ce = 1'b0;
    @(negedge clk); reset = 1'b0;
    do_txn(1'b1, 16'h0001, 8'h00, 8'h96, 0, 0, 1'b0, lat, rl);
    exp_data = 8'h96;
    n_checks++;
    if (lat !== 81 || sck_cnt !== 40 || mosi_frame !== 40'h0300_0001_00 || o_spi_data !== exp_data) begin
      n_fail++; $display("FAIL after_reset_read: lat %0d sck %0d mosi %h data %h, required 81 40 0300000100 %h",
                         lat, sck_cnt, mosi_frame, o_spi_data, exp_data);
    end
  endtask

  task automatic test_back_to_back;
    int lat, rl;
    logic [15:0] a1, a2;
    logic [7:0] mb, d2;
    logic [39:0] f1;
    a1 = 16'($urandom); a2 = 16'($urandom); mb = 8'($urandom); d2 = 8'($urandom);
    do_txn(1'b1, a1, 8'h00, mb, 0, 0, 1'b0, lat, rl);
    f1 = mosi_frame;
    exp_data = mb;
    n_checks++;
    if (lat !== 81 || f1 !== model_frame(1'b1, a1, 8'h00) || o_spi_data !== exp_data) begin
      n_fail++; $display("FAIL b2b_read: lat %0d mosi %h data %h, required 81 %h %h",
                         lat, f1, o_spi_data, model_frame(1'b1, a1, 8'h00), exp_data);
    end
    do_txn(1'b0, a2, d2, 8'h00, 0, 0, 1'b1, lat, rl);
    n_checks++;
    if (lat !== 81 || mosi_frame !== model_frame(1'b0, a2, d2) || o_spi_data !== exp_data) begin
      n_fail++; $display("FAIL b2b_write: lat %0d mosi %h data %h, required 81 %h %h",
                         lat, mosi_frame, o_spi_data, model_frame(1'b0, a2, d2), exp_data);
    end
    n_checks++;
    if (cs_gap < 20) begin n_fail++; $display("FAIL b2b_cs_gap: %0t, required >= 20", cs_gap); end
  endtask

  task automatic test_random;
    int lat, rl;
    logic rw;
    logic [15:0] a;
    logic [7:0] d, mb;
    for (int i = 0; i < 6; i++) begin
      rw = 1'($urandom); a = 16'($urandom); d = 8'($urandom); mb = 8'($urandom);
      do_txn(rw, a, d, mb, 0, 0, 1'b0, lat, rl);
      if (rw) exp_data = mb;
      n_checks++;
      if (lat !== 81 || sck_cnt !== 40 || mosi_frame !== model_frame(rw, a, d) ||
          o_spi_data !== exp_data || rl !== 1) begin
        n_fail++; $display("FAIL random_%0d: lat %0d sck %0d mosi %h data %h rdy %0d, required 81 40 %h %h 1",
                           i, lat, sck_cnt, mosi_frame, o_spi_data, rl, model_frame(rw, a, d), exp_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_directed();
    test_read_early_drop();
    test_write_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_flash_controller.md
# spi_flash_controller

Bridges the CPU-side parallel memory bus to an external SPI NOR flash. It issues a single-byte flash READ (0x03) or PAGE PROGRAM (0x02) transaction when selected, and returns the byte read. It flags completion to the bus via `o_MemoryReady`. It sits between the address decoder, which drives `spi_ce`, and the flash device pins.

## Interface
- `READ_CMD`, 8'h03, opcode for read.
- `WRITE_CMD`, 8'h02, opcode for page program.
- `ADDR_HI`, 8'h00, upper byte of the 24-bit flash address.
- `clk` in 1: system clock (88.67 MHz nominal). One clock; reset is asynchronous and active-high.
- `reset` in 1: asynchronous, active-high reset.
- `spi_ce` in 1: chip select from the bus decoder; high requests a transaction.
- `i_ADDRESS_BUS` in 16: byte address.
- `i_DataBus` in 8: write data.
- `i_RW` in 1: 1 = read, 0 = write.
- `i_SPI_MISO` in 1: flash serial data out.
- `o_SPI_CLK` out 1: SCK, SPI mode 0.
- `o_SPI_MOSI` out 1: flash serial data in.
- `o_SPI_CS` out 1: flash chip select, active-low.
- `o_spi_data` out 8: last byte read.
- `o_MemoryReady` out 1: transaction complete.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE → SHIFT:** taken when `spi_ce`=1. On that edge:
  - latch `i_RW`, `i_ADDRESS_BUS` and `i_DataBus`;
  - load a 40-bit shift frame: `{cmd, ADDR_HI, addr[15:8], addr[7:0], wdata}`;
  - `cmd` is `READ_CMD` or `WRITE_CMD`; `wdata` is ignored/0 for reads.
- **SHIFT:**
  - CS low; 40 SCK periods; MSB first.
  - MOSI changes on the SCK falling edge (and the first bit is set at CS fall); MISO is sampled on the rising edge.
  - Reads capture MISO during bits 32..39 into an 8-bit shift register. Writes ignore MISO.
- **SHIFT → DONE:** after the 40th falling edge.
  - CS high, SCK low.
  - Read: `o_spi_data` ← captured byte.
  - Write: `o_spi_data` is unchanged.
  - `o_MemoryReady` = 1.
- **DONE:** `o_MemoryReady` stays 1 while `spi_ce`=1. When `spi_ce`=0, go to IDLE (ready drops). No retrigger without `spi_ce` going low first.
- `spi_ce` falling during SHIFT does not abort. The transaction completes, then DONE lasts exactly one cycle.
- Input changes after the start edge are ignored.
- Write-enable (0x06) is not issued by this block. Software or a prior transaction is responsible for it.

## Timing
- Reset values: `o_SPI_CS`=1, `o_SPI_CLK`=0, `o_SPI_MOSI`=0, `o_spi_data`=8'h00, `o_MemoryReady`=0, state IDLE.
- SCK = clk/2; each SCK level lasts 1 clk.
- Cycle sequence, with E0 the edge that samples `spi_ce`=1:
  - E0: CS falls and MOSI carries bit 39.
  - Odd edges E1..E79: SCK rises and MISO is sampled.
  - Even edges E2..E80: SCK falls and MOSI shifts.
  - E81: CS rises, `o_MemoryReady` rises, `o_spi_data` updates.
- Latency from the start edge to ready: 81 clk (about 914 ns).
- CS high time between transactions: at least 2 clk (DONE plus IDLE).
- Reset asserted mid-transaction: immediately return to reset values (CS high); the partial flash command is discarded.

## Structure
- Shared package:
  - opcode constants (`READ_CMD`, `WRITE_CMD`, `WREN`=8'h06);
  - state enum;
  - frame length constant 40;
  - data-phase start bit 32.
- Natural sub-module: `spi_shift_engine`, a generic N-bit mode-0 shifter with CS/SCK generation and MISO capture. The top holds only bus latching and the IDLE/DONE handshake.

## Test plan
- **Reset:** pulse `reset`. Expect CS=1, SCK=0, MOSI=0, `o_spi_data`=00, ready=0; no SCK activity while `spi_ce`=0.
- **Read 0x3AAA, normal:**
  - Stimulus: `i_RW`=1, `spi_ce`=1; drive MISO bits 1,1,1,1,1,0,1,0 on data-phase rising edges.
  - Expect: MOSI stream 03 00 3A AA; exactly 40 SCK pulses; `o_spi_data`=FA; ready high at E81.
- **Read, `spi_ce` dropped early:** same read with `spi_ce` dropped at E50. Transaction completes and ready pulses exactly 1 cycle.
- **Write 0x3000 / AA:** `i_RW`=0. Expect MOSI 02 00 30 00 AA; `o_spi_data` unchanged; ready at E81; no retrigger while `spi_ce` is held high.
- **Reset mid-frame:** assert reset at E20. Expect CS high and SCK low immediately; a subsequent read of 0x0001 produces a correct, complete frame.
- **Back-to-back:** read then write, with `spi_ce` low for 1 clk between them. Both frames are correct and CS is high for at least 2 clk between them.
